pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the PC, offset and target width in bits.
REQ-002 The module SHALL have parameter RESET_VECTOR, default 32'h3000, giving the PC value loaded at reset.
REQ-003 The module SHALL have parameter STEP, default 4, giving the sequential PC increment.
REQ-004 The module SHALL have parameter RAS_DEPTH, default 4 (legal range 2..16), giving the number of return-address stack entries.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-008 The module SHALL have port branch_taken, input, 1 bit: take the PC-relative branch.
REQ-009 The module SHALL have port branch_offset, input, WIDTH bits: two's-complement byte offset.
REQ-010 The module SHALL have port jump, input, 1 bit: absolute jump.
REQ-011 The module SHALL have port call, input, 1 bit: absolute jump plus push of the return address.
REQ-012 The module SHALL have port jump_target, input, WIDTH bits: absolute target for jump and call.
REQ-013 The module SHALL have port ret, input, 1 bit: pop the return address into the PC.
REQ-014 The module SHALL have port pc_out, output, WIDTH bits: current PC, driven from a register.
REQ-015 The module SHALL have port ras_empty, output, 1 bit: stack holds 0 entries.
REQ-016 The module SHALL have port ras_full, output, 1 bit: stack holds RAS_DEPTH entries.
REQ-017 The module SHALL have port ras_err, output, 1 bit: sticky flag for overflow, underflow or illegal command.

Function
REQ-018 Each unstalled cycle, pc_out SHALL update with exactly one action, chosen in priority order: illegal command > ret > call > jump > branch_taken > sequential.
REQ-019 stall=1 SHALL hold pc_out, the stack contents, the stack count and ras_err unchanged, regardless of any other input.
REQ-020 Sequential: pc_out SHALL become pc_out+STEP, modulo 2^WIDTH.
REQ-021 Branch: pc_out SHALL become pc_out+branch_offset, modulo 2^WIDTH; a negative offset moves the PC backward.
REQ-022 Jump: pc_out SHALL become jump_target.
REQ-023 Call: the module SHALL push pc_out+STEP and set pc_out to jump_target.
REQ-024 Ret with the stack non-empty: the module SHALL pop the top entry into pc_out.
REQ-025 Ret with the stack empty: pc_out SHALL become pc_out+STEP, the count SHALL stay 0, and ras_err SHALL set.
REQ-026 Call with the stack full: the push SHALL overwrite the oldest entry (circular buffer), the count SHALL stay RAS_DEPTH, and ras_err SHALL set; pc_out SHALL still become jump_target.
REQ-027 call=1 and ret=1 in the same cycle SHALL be an illegal command: pc_out becomes pc_out+STEP, the stack is unchanged, and ras_err sets.
REQ-028 jump or branch_taken asserted together with call or ret SHALL be ignored, following the REQ-018 priority, and SHALL NOT set ras_err.
REQ-029 The stack SHALL be a RAS_DEPTH-entry circular buffer with a top pointer and a saturating count; ras_empty and ras_full SHALL be derived from the registered count.
REQ-030 The stack pointer SHALL wrap modulo RAS_DEPTH, including for non-power-of-two depths.
REQ-031 ras_err SHALL stay set until reset.
REQ-032 Latency SHALL be one cycle: a command sampled at edge N is visible on pc_out after edge N.
REQ-033 pc_out SHALL NOT depend combinationally on any input.

Reset
REQ-034 While rst_n=0, pc_out SHALL be RESET_VECTOR, the count SHALL be 0, ras_empty SHALL be 1, ras_full SHALL be 0, and ras_err SHALL be 0, asynchronously to clk.
REQ-035 Stack entry contents SHALL NOT need a reset value.
REQ-036 Reset asserted mid-operation SHALL discard all pending stack state.
REQ-037 The first edge after rst_n rises, with no command asserted, SHALL produce RESET_VECTOR+STEP.

Verification
REQ-038 Reset, then 3 idle cycles -> pc_out reads 0x3000, 0x3004, 0x3008, 0x300C.
REQ-039 At pc 0x3010: branch_offset=0xFFFFFFF8 -> 0x3008; stall=1 for 2 cycles -> pc_out holds 0x3008.
REQ-040 At pc 0x3000: call target 0x4000, then at 0x4000 call target 0x5000, then ret, then ret -> pc_out reads 0x4000, 0x5000, 0x4004, 0x3004; ras_empty=1; ras_err=0.
REQ-041 5 nested calls with RAS_DEPTH=4 -> ras_full=1 and ras_err=1 after the 5th call; 4 rets return the 4 newest return addresses, oldest first lost.
REQ-042 Ret on empty stack at pc 0x3000 -> pc_out=0x3004, ras_err=1; call=ret=1 together -> pc_out advances by STEP and the stack is unchanged.
REQ-043 At pc 0xFFFFFFFC: sequential step -> pc_out=0x00000000; assert rst_n=0 between clock edges -> pc_out=0x3000 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_sequencer: program counter with branch/jump/call/ret and circular RAS |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h3000),
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_offset,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int               PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int               CW       = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [PW-1:0]    PTR_LAST = PW'(RAS_DEPTH - 1);
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [WIDTH-1:0] pc_q, pc_d, seq_pc;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d, push;

  // ptr_q is the next free slot; when full it also addresses the oldest entry,
  // so an overflowing push naturally overwrites the oldest return address.
  always_comb begin
    seq_pc  = pc_q + STEP_W;
    ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
    ptr_dec = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_ONE;
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push    = 1'b0;
    if (!stall) begin
      if (call && ret) begin
        pc_d  = seq_pc;
        err_d = 1'b1;
      end else if (ret) begin
        if (cnt_q == '0) begin
          pc_d  = seq_pc;
          err_d = 1'b1;
        end else begin
          pc_d  = stack[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CNT_ONE;
        end
      end else if (call) begin
        push  = 1'b1;
        pc_d  = jump_target;
        ptr_d = ptr_inc;
        if (cnt_q == CNT_FULL) err_d = 1'b1;
        else                   cnt_d = cnt_q + CNT_ONE;
      end else if (jump) begin
        pc_d = jump_target;
      end else if (branch_taken) begin
        pc_d = pc_q + branch_offset;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry contents are qualified by the count, so they carry no reset.
  always_ff @(posedge clk) begin
    if (push) stack[ptr_q] <= seq_pc;
  end

  assign pc_out    = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_FULL);
  assign ras_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// Self-checking bench for pc_sequencer: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] branch_offset = '0, jump_target = '0;
  logic [31:0] pc_out;
  logic        ras_empty, ras_full, ras_err;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(32), .RESET_VECTOR(32'h3000), .STEP(4), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .call(call), .jump_target(jump_target),
    .ret(ret), .pc_out(pc_out), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, br, jmp, cal, rt;
    logic [31:0] off, tgt;
    logic [31:0] exp_pc;
    logic        exp_empty, exp_full, exp_err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic s, logic b, logic [31:0] o, logic j, logic c,
                              logic [31:0] t, logic r, logic [31:0] pc,
                              logic e, logic f, logic er);
    vec_t v;
    v.stall = s; v.br = b; v.off = o; v.jmp = j; v.cal = c; v.tgt = t; v.rt = r;
    v.exp_pc = pc; v.exp_empty = e; v.exp_full = f; v.exp_err = er;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] epc, logic ee, logic ef, logic eer);
    checks++;
    if (pc_out !== epc || ras_empty !== ee || ras_full !== ef || ras_err !== eer) begin
      errors++;
      $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
               name, pc_out, ras_empty, ras_full, ras_err, epc, ee, ef, eer);
    end
  endtask

  task automatic drive(logic s, logic b, logic [31:0] o, logic j, logic c, logic [31:0] t, logic r);
    stall = s; branch_taken = b; branch_offset = o; jump = j; call = c; jump_target = t; ret = r;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Apply current inputs across one rising edge; sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check("reset_values", 32'h3000, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: PC plus a queue of return addresses (newest at the back).
  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_q[$];

  task automatic model_step(logic s, logic b, logic [31:0] o, logic j, logic c, logic [31:0] t, logic r);
    if (s) return;
    if (c && r) begin
      m_pc += 32'd4; m_err = 1'b1;
    end else if (r) begin
      if (m_q.size() == 0) begin m_pc += 32'd4; m_err = 1'b1; end
      else m_pc = m_q.pop_back();
    end else if (c) begin
      m_q.push_back(m_pc + 32'd4);
      if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_err = 1'b1; end
      m_pc = t;
    end else if (j) m_pc = t;
    else if (b) m_pc += o;
    else m_pc += 32'd4;
  endtask

  initial begin
    vecs[0]  = mk(0,0,32'h0,       0,0,32'h0,   0, 32'h3004, 1,0,0);
    vecs[1]  = mk(0,0,32'h0,       0,0,32'h0,   0, 32'h3008, 1,0,0);
    vecs[2]  = mk(0,0,32'h0,       0,0,32'h0,   0, 32'h300C, 1,0,0);
    vecs[3]  = mk(0,0,32'h0,       0,0,32'h0,   0, 32'h3010, 1,0,0);
    vecs[4]  = mk(0,1,32'hFFFFFFF8,0,0,32'h0,   0, 32'h3008, 1,0,0);
    vecs[5]  = mk(1,0,32'h0,       0,0,32'h0,   0, 32'h3008, 1,0,0);
    vecs[6]  = mk(1,1,32'h40,      1,1,32'h9000,0, 32'h3008, 1,0,0);
    vecs[7]  = mk(0,0,32'h0,       1,0,32'h3000,0, 32'h3000, 1,0,0);
    vecs[8]  = mk(0,0,32'h0,       0,1,32'h4000,0, 32'h4000, 0,0,0);
    vecs[9]  = mk(0,0,32'h0,       0,1,32'h5000,0, 32'h5000, 0,0,0);
    vecs[10] = mk(0,0,32'h0,       0,0,32'h0,   1, 32'h4004, 0,0,0);
    vecs[11] = mk(0,0,32'h0,       0,0,32'h0,   1, 32'h3004, 1,0,0);
    vecs[12] = mk(0,1,32'h100,     1,0,32'h3000,0, 32'h3000, 1,0,0);
    vecs[13] = mk(0,1,32'h100,     1,1,32'h4000,0, 32'h4000, 0,0,0);
    vecs[14] = mk(0,1,32'h100,     1,0,32'h8000,1, 32'h3004, 1,0,0);
    vecs[15] = mk(0,0,32'h0,       0,0,32'h0,   1, 32'h3008, 1,0,1);

    // Directed vector table
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].off, vecs[i].jmp, vecs[i].cal, vecs[i].tgt, vecs[i].rt);
      tick();
      check($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_err);
    end

    // Overflow: 5 nested calls into a 4-deep stack, oldest return address lost
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 1, 32'(k) << 16, 0);
      tick();
      check($sformatf("ovf_call%0d", k), 32'(k) << 16, 1'b0, k >= 4, k == 5);
    end
    for (int k = 4; k >= 1; k--) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
      check($sformatf("ovf_ret%0d", k), (32'(k) << 16) + 32'd4, k == 1, 1'b0, 1'b1);
    end

    // Illegal call+ret leaves the stack untouched
    do_reset();
    drive(0, 0, 0, 0, 1, 32'h4000, 0); tick();
    check("ill_call", 32'h4000, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 1, 1, 32'h7000, 1); tick();
    check("ill_callret", 32'h4004, 1'b0, 1'b0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    check("ill_ret_after", 32'h3004, 1'b1, 1'b0, 1'b1);

    // PC wrap, then asynchronous reset mid-cycle with a live stack
    drive(0, 0, 0, 0, 1, 32'hFFFFFFF8, 0); tick();
    drive(0, 0, 0, 1, 0, 32'hFFFFFFFC, 0); tick();
    check("wrap_pre", 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1);
    idle_inputs(); tick();
    check("wrap", 32'h00000000, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h3000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("first_after_reset", 32'h3004, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    check("ret_after_reset", 32'h3008, 1'b1, 1'b0, 1'b1);

    // Randomized traffic against the reference model
    do_reset();
    m_pc = 32'h3000; m_err = 1'b0; m_q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic s, b, j, c, r;
      logic [31:0] o, t;
      if (n == 1500) begin
        do_reset();
        m_pc = 32'h3000; m_err = 1'b0; m_q.delete();
      end
      s = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 4) == 0);
      o = $urandom_range(0, 1) ? 32'($signed(-$urandom_range(0, 64)) * 4) : 32'($urandom_range(0, 64) * 4);
      t = $urandom & 32'hFFFF_FFFC;
      if (n < 1500 && $urandom_range(0, 7) != 0) r = 1'b0;
      drive(s, b, o, j, c, t, r);
      tick();
      model_step(s, b, o, j, c, t, r);
      check($sformatf("rand%0d", n), m_pc, m_q.size() == 0, m_q.size() == DEPTH, m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
